backing_ram: RTL and testbench
==============================

// Module: backing_ram
// PURPOSE
//   Word-addressed backing memory behind the L1 cache, with a fixed multi-cycle access latency.
//   It services one read or write request at a time and flags completion on 'response'.
//   A request is level-presented: the cache holds data/addr/wr stable until response rises.
//   A change on any of those inputs starts a new request.
// PARAMETERS
//   DEPTH    1024  number of 32-bit words in the array
//   ADDR_W   10    index width; word index = addr[ADDR_W-1:0]; addr[31:ADDR_W] ignored
//   LATENCY  4     cycles from request-accept edge to response assertion (legal range 1..15)
// PORTS
//   clk       in   1   single clock; all state changes on posedge
//   rst_n     in   1   asynchronous, active-low reset
//   data      in   32  write data; also part of request identity
//   addr      in   32  word address (low ADDR_W bits used)
//   wr        in   1   1 = write request, 0 = read request
//   response  out  1   high when the current request has completed; stays high until the next request
//   out       out  32  read data, or the echoed write data, valid while response=1
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//       - response=0, out=0, busy=0, req_seen=0.
//       - Latched request copy {data,addr,wr} cleared to 0.
//       - Array contents are NOT reset; they are zero-initialised at time 0 for simulation.
//   - Request accept, at a posedge with rst_n=1, when req_seen=0 OR {data,addr,wr} != latched copy:
//       - Latch the inputs, set req_seen=1 and busy=1, drop response to 0, load countdown = LATENCY-1.
//       - Write request: mem[idx] <= data on this same edge.
//   - While busy and no new request:
//       - If countdown != 0, decrement.
//       - If countdown == 0: busy=0 and response=1.
//         - Read: out = mem[latched idx], sampled on this edge.
//         - Write: out = latched data.
//   - Latency: response rises exactly LATENCY posedges after the accept edge. With LATENCY=1 it rises on the next edge.
//   - Idle with unchanged inputs: response and out hold their values; no array access.
//   - New request while busy: the old request is abandoned.
//       - No response is produced for it.
//       - A write it carried is already committed.
//       - The new request restarts the full latency.
//   - Accept edge and completion edge coincide: the accept wins (response=0).
//   - Read-after-write to the same index returns the newly written data.
//   - Reset mid-operation: the pending request is discarded; writes already committed remain in the array.
//   - The first request after reset is accepted even if its inputs are all zero.
// TESTING
//   - Reset: drive rst_n=0 mid-cycle -> response=0 and out=0 immediately, without waiting for a clock edge.
//   - Write then read:
//       - Write addr=5, data=32'hDEADBEEF -> response=1 after 4 edges, out=DEADBEEF.
//       - Then read addr=5 -> response low on the accept edge, high 4 edges later, out=DEADBEEF.
//   - Address aliasing: write addr=32'h0000_0405 with data=32'h1234 -> a read of addr=5 returns 32'h1234.
//   - Abort: start a read of addr=7, then change addr to 9 after 2 edges -> a single response, 4 edges after the second accept, with out=mem[9].
//   - Hold: keep inputs stable for 20 cycles after response -> response stays 1 and out is unchanged.
//   - Post-reset zero request: rst_n released with data=0, addr=0, wr=0 -> response=1 after LATENCY edges, out=0.

Source files
------------

// File: rtl/backing_ram.sv
// backing_ram: word-addressed backing store behind the L1 cache.
// One level-presented request at a time. A request is accepted on the first
// edge after reset, or on any edge where {data,addr,wr} differs from the
// latched copy. The response is raised LATENCY edges after the accept edge.
module backing_ram #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out
);

  localparam int unsigned CNT_W = 4;

  // Storage array; zero at time 0 for simulation, never cleared by reset
  logic [31:0] r_mem [DEPTH] = '{default: '0};

  logic [31:0]      r_data;
  logic [31:0]      r_addr;
  logic             r_wr;
  logic             r_seen;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_resp;
  logic [31:0]      r_out;

  logic              w_new_req;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_lat_idx;

  // A new request is any change of the presented tuple, or the first one after reset
  always_comb begin
    w_new_req = 1'b0;
    if (!r_seen || ({data, addr, wr} != {r_data, r_addr, r_wr})) begin
      w_new_req = 1'b1;
    end
  end

  assign w_idx     = addr[ADDR_W-1:0];
  assign w_lat_idx = r_addr[ADDR_W-1:0];

  // Writes commit to the array on the accept edge; upper address bits alias
  always_ff @(posedge clk) begin
    if (rst_n && w_new_req && wr) begin
      r_mem[w_idx] <= data;
    end
  end

  // Request latch, latency countdown and response generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_addr <= '0;
      r_wr   <= 1'b0;
      r_seen <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_resp <= 1'b0;
      r_out  <= '0;
    end else if (w_new_req) begin
      // Accept takes priority over a completion landing on the same edge
      r_data <= data;
      r_addr <= addr;
      r_wr   <= wr;
      r_seen <= 1'b1;
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(LATENCY - 1);
      r_resp <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_busy <= 1'b0;
        r_resp <= 1'b1;
        r_out  <= r_wr ? r_data : r_mem[w_lat_idx];
      end
    end
  end

  assign response = r_resp;
  assign out      = r_out;

endmodule

// File: tb/tb_backing_ram.sv
// Directed self-checking bench for backing_ram (LATENCY=4 main instance,
// LATENCY=1 companion instance sharing the same request inputs).
module tb_backing_ram;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        response;
  logic [31:0] out;
  logic        response1;
  logic [31:0] out1;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  backing_ram #(.DEPTH(1024), .ADDR_W(10), .LATENCY(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .addr     (addr),
    .wr       (wr),
    .response (response),
    .out      (out)
  );

  backing_ram #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .addr     (addr),
    .wr       (wr),
    .response (response1),
    .out      (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] d, input logic [31:0] a, input logic w);
    data = d;
    addr = a;
    wr   = w;
  endtask

  // Accept edge, then four-edge latency on the main instance, one on the companion
  task automatic run_latency(input string tag, input logic [31:0] exp_out);
    tick();
    check({tag, "_acc_resp"}, {31'd0, response}, 32'd0);
    check({tag, "_acc_resp1"}, {31'd0, response1}, 32'd0);
    tick();
    check({tag, "_l1_resp"}, {31'd0, response1}, 32'd1);
    check({tag, "_l1_out"}, out1, exp_out);
    check({tag, "_e1_resp"}, {31'd0, response}, 32'd0);
    tick();
    check({tag, "_e2_resp"}, {31'd0, response}, 32'd0);
    tick();
    check({tag, "_e3_resp"}, {31'd0, response}, 32'd0);
    tick();
    check({tag, "_e4_resp"}, {31'd0, response}, 32'd1);
    check({tag, "_e4_out"}, out, exp_out);
  endtask

  initial begin
    rst_n = 1'b1;
    req(32'd0, 32'd0, 1'b0);

    // Asynchronous reset visible before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_resp", {31'd0, response}, 32'd0);
    check("rst_async_out", out, 32'd0);
    tick();
    tick();
    check("rst_hold_resp", {31'd0, response}, 32'd0);

    // First request after reset is all-zero and must still be serviced
    #3 rst_n = 1'b1;
    run_latency("zero_req", 32'd0);

    // Write then read back
    req(32'hDEADBEEF, 32'd5, 1'b1);
    run_latency("wr5", 32'hDEADBEEF);
    req(32'd0, 32'd5, 1'b0);
    run_latency("rd5", 32'hDEADBEEF);

    // Stable inputs after response: outputs hold
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_resp", {31'd0, response}, 32'd1);
      check("hold_out", out, 32'hDEADBEEF);
    end

    // Upper address bits alias onto the same word
    req(32'h0000_1234, 32'h0000_0405, 1'b1);
    run_latency("wr405", 32'h0000_1234);
    req(32'd0, 32'd5, 1'b0);
    run_latency("rd5_alias", 32'h0000_1234);

    // Distinct contents at 7 and 9
    req(32'h0000_0077, 32'd7, 1'b1);
    run_latency("wr7", 32'h0000_0077);
    req(32'h0000_0099, 32'd9, 1'b1);
    run_latency("wr9", 32'h0000_0099);

    // Abort: read 7, switch to 9 after two edges; only one response, for 9
    req(32'd0, 32'd7, 1'b0);
    tick();
    check("abort_acc_resp", {31'd0, response}, 32'd0);
    tick();
    check("abort_e1_resp", {31'd0, response}, 32'd0);
    req(32'd0, 32'd9, 1'b0);
    run_latency("abort_rd9", 32'h0000_0099);

    // New accept on the old request's completion edge: accept wins
    req(32'd0, 32'd7, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("coin_pre_resp", {31'd0, response}, 32'd0);
    req(32'd0, 32'd5, 1'b0);
    run_latency("coin_rd5", 32'h0000_1234);

    // Reset mid-operation: committed write survives, pending request dropped
    req(32'h0000_0033, 32'd3, 1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_resp", {31'd0, response}, 32'd0);
    check("rst_mid_out", out, 32'd0);
    check("rst_mid_resp1", {31'd0, response1}, 32'd0);
    check("rst_mid_out1", out1, 32'd0);
    tick();
    tick();
    check("rst_mid_hold", {31'd0, response}, 32'd0);
    req(32'd0, 32'd3, 1'b0);
    #3 rst_n = 1'b1;
    run_latency("rd3_after_rst", 32'h0000_0033);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
